// File: rtl/mem_responder.sv
// mem_responder: fixed-latency single-port memory responder; define MEM_RESP_ERR_CHECK_EN to flag misaligned/out-of-range accesses.
module mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_adr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_be,
   output logic        o_ready,
   output logic        o_rvalid,
   output logic [31:0] o_rdata,
   output logic        o_err
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t          state, state_nx;
   logic [3:0]      cnt, cnt_nx;
   logic            we_q, err_q, acc, err_in;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic [3:0]      be_q;
   logic [31:0]     mem [DEPTH];
   assign acc = state == IDLE && i_req;
`ifdef MEM_RESP_ERR_CHECK_EN
   // 4*DEPTH is a power of two, so out-of-range means any bit above the index is set
   assign err_in = (i_adr[1:0] != 2'b00) || (|i_adr[31:AW+2]);
`else
   logic unused;
   assign unused = ^{i_adr[31:AW+2], i_adr[1:0]};
   assign err_in = 1'b0;
`endif
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (acc) begin
            we_q    <= i_we;
            err_q   <= err_in;
            idx_q   <= i_adr[AW+1:2];
            wdata_q <= i_wdata;
            be_q    <= i_be;
         end
      end
   end
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: if (i_req) begin
            state_nx = (LATENCY == 1) ? RESP : WAIT;
            cnt_nx   = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
         end
         WAIT: if (cnt == 4'd0) state_nx = RESP;
               else cnt_nx = cnt - 4'd1;
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      o_ready  = state == IDLE && i_rstn;
      o_rvalid = state == RESP;
      o_err    = state == RESP && err_q;
      o_rdata  = (state == RESP && !we_q && !err_q) ? mem[idx_q] : 32'h0;
   end
   // memory has no reset; an async reset moves state out of RESP, so aborted writes never commit
   always_ff @(posedge i_clk) begin
      if (state == RESP && we_q && !err_q)
         for (int b = 0; b < 4; b++)
            if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
   end
endmodule
